// File: rtl/noc_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : noc_port_fifo
//  Purpose  : Router input-port flit FIFO. First-word-fall-through, with
//             almost-full backpressure and a saturating refused-flit counter.
//  Ports    : clk, rst (async, active-low), flush (sync clear)
//             in_valid / in_data / in_ready     - upstream push handshake
//             out_valid / out_data / out_ready  - downstream pop handshake
//             count       - occupancy 0..DEPTH
//             almost_full - count >= AF_LEVEL
//             drop_cnt    - saturating count of in_valid cycles refused while full
//  Revision : 1.0  initial release
// ============================================================================
module noc_port_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              push;
    logic              pop;
    logic              refuse;

    // Handshake status depends on stored state only; a pop in the same
    // cycle never opens room for a push when full.
    assign in_ready    = (count_q < CNT_W'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
    assign drop_cnt    = drop_cnt_q;

    assign push   = in_valid  && in_ready  && !flush;
    assign pop    = out_valid && out_ready && !flush;
    assign refuse = in_valid  && !in_ready && !flush;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap by natural overflow (DEPTH is a power of two).
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (refuse && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_port_fifo
//  Purpose  : Self-checking bench for noc_port_fifo (DATA_W=8, DEPTH=8,
//             AF_LEVEL=6). Queue-based reference model, directed scenarios
//             followed by randomized traffic with flushes and reset pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_port_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [3:0]        count;
    logic              almost_full;
    logic [7:0]        drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    int         model_drop = 0;

    always #5 clk = ~clk;

    noc_port_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full),
        .drop_cnt    (drop_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every observable output against the reference model.
    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check_val({tag, ".count"},       32'(count),       32'(sz));
        check_val({tag, ".out_valid"},   32'(out_valid),   32'(sz != 0));
        check_val({tag, ".in_ready"},    32'(in_ready),    32'(sz < DEPTH));
        check_val({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF_LEVEL));
        check_val({tag, ".drop_cnt"},    32'(drop_cnt),    32'(model_drop));
        if (sz != 0) begin
            check_val({tag, ".out_data"}, 32'(out_data), 32'(model_q[0]));
        end
    endtask

    // Reference behaviour of one rising edge, from the current inputs.
    task automatic model_edge();
        bit do_push;
        bit do_pop;
        if (flush) begin
            model_q.delete();
        end else begin
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (in_valid && !do_push && model_drop < 255) model_drop++;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        model_q.delete();
        model_drop = 0;
        check_state(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] rx[$];
        int         n;
        int         guard;

        rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b1;

        // Fill with 0x11..0x18, nothing drained.
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(8'h11 + i), 0, 0);
            cycle();
            check_state("fill");
            check_val("fill.af", 32'(almost_full), 32'((i + 1) >= AF_LEVEL));
        end
        check_val("full.in_ready", 32'(in_ready), 32'd0);
        check_val("full.head",     32'(out_data), 32'h11);

        // Offer while full for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hAA, 0, 0);
            cycle();
            check_state("refuse");
        end
        check_val("refuse.drop", 32'(drop_cnt), 32'd3);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            drive(0, 8'h00, 1, 0);
            check_val("drain.data", 32'(out_data), 32'(8'h11 + i));
            cycle();
            check_state("drain");
        end
        check_val("drain.empty", 32'(out_valid), 32'd0);

        // Streaming: 20 flits, both sides always active.
        rx.delete();
        n = 0;
        guard = 0;
        while ((n < 20 || out_valid) && guard < 100) begin
            if (n < 20) drive(1, 8'(n), 1, 0);
            else        drive(0, 8'h00, 1, 0);
            if (out_valid) rx.push_back(out_data);
            cycle();
            if (n < 20) begin
                check_val("stream.count", 32'(count), 32'd1);
                n++;
            end
            check_state("stream");
            guard++;
        end
        check_val("stream.timeout", 32'(guard < 100), 32'd1);
        check_val("stream.len", 32'(rx.size()), 32'd20);
        for (int i = 0; i < rx.size(); i++) begin
            check_val("stream.order", 32'(rx[i]), 32'(i));
        end
        check_val("stream.drop", 32'(drop_cnt), 32'd3);

        // Full, push and pop together: only the pop happens.
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(8'h30 + i), 0, 0);
            cycle();
        end
        drive(1, 8'hBB, 1, 0);
        cycle();
        check_state("fullpp");
        check_val("fullpp.count", 32'(count),    32'd7);
        check_val("fullpp.head",  32'(out_data), 32'h31);
        check_val("fullpp.drop",  32'(drop_cnt), 32'd4);

        // Flush beats push and pop.
        drive(0, 8'h00, 0, 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            cycle();
        end
        drive(1, 8'hCC, 1, 1);
        cycle();
        check_state("flush");
        check_val("flush.count", 32'(count),    32'd0);
        check_val("flush.drop",  32'(drop_cnt), 32'd4);
        drive(1, 8'h77, 0, 0);
        cycle();
        check_state("postflush");
        check_val("postflush.head", 32'(out_data), 32'h77);

        // Asynchronous reset mid-transfer.
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h50 + i), 0, 0);
            cycle();
        end
        drive(0, 8'h00, 0, 0);
        pulse_reset("areset");
        check_val("areset.count", 32'(count), 32'd0);
        drive(1, 8'h5A, 0, 0);
        cycle();
        check_state("postrst");
        check_val("postrst.head", 32'(out_data), 32'h5A);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            drive(1, 8'(i), 0, 0);
            cycle();
        end
        check_state("sat");
        check_val("sat.drop", 32'(drop_cnt), 32'd255);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset("rnd.rst");
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0));
            if (i % 500 < 60) out_ready = 1'b0;
            cycle();
            check_state("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_port_fifo.md
NOC_PORT_FIFO -- requirements
Module: noc_port_fifo

Interface
REQ-001 Parameter DATA_W, default 8, flit width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, >= 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all stored flits.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_data  input  DATA_W  flit from upstream.
REQ-009 in_ready  output  1  FIFO can accept a flit this cycle.
REQ-010 out_valid  output  1  out_data holds the oldest stored flit.
REQ-011 out_data  output  DATA_W  head flit, first-word-fall-through.
REQ-012 out_ready  input  1  downstream consumes the head flit this cycle.
REQ-013 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 almost_full  output  1  count >= AF_LEVEL; for link-level backpressure to the neighbour router.
REQ-015 drop_cnt  output  8  saturating count of in_valid cycles refused while full.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH), combinational from state only, independent of out_ready (no write-through at full).
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL be storage[rd_ptr], no read latency.
REQ-019 Flit pushed in cycle N SHALL appear on out_data with out_valid in cycle N+1 when the FIFO was empty; no same-cycle bypass.
REQ-020 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-021 Push only: write storage[wr_ptr], wr_ptr+1, count+1.
REQ-022 Pop only: rd_ptr+1, count-1.
REQ-023 Push and pop same cycle (0 < count < DEPTH): both pointers advance, count unchanged, data order preserved.
REQ-024 At count==DEPTH with in_valid and out_ready: pop only; push refused; drop_cnt increments.
REQ-025 At count==0 with in_valid and out_ready: push only; out_ready ignored.
REQ-026 Refused flit (in_valid && !in_ready) SHALL increment drop_cnt, saturating at 255; never wraps.
REQ-027 flush SHALL take priority over push and pop: next cycle rd_ptr=wr_ptr=0, count=0; storage contents don't-care; drop_cnt unchanged.
REQ-028 almost_full SHALL be derived combinationally from count.
REQ-029 count SHALL never exceed DEPTH nor underflow below 0 under any input combination.

Reset
REQ-030 On rst low, asynchronously: rd_ptr=0, wr_ptr=0, count=0, drop_cnt=0; hence out_valid=0, in_ready=1, almost_full=0 (AF_LEVEL>=1).
REQ-031 out_data during reset and when empty is don't-care; bench SHALL not check it while out_valid=0.
REQ-032 Storage array SHALL not be reset.
REQ-033 Reset asserted mid-transfer SHALL discard all flits; first push after rst release is accepted normally; release synchronous to clk by integration.

Verification (DATA_W=8, DEPTH=8, AF_LEVEL=6)
REQ-034 Push 0x11..0x18 with out_ready=0 -> count 1..8, almost_full from 6th push, in_ready=0 after 8th, out_data=0x11.
REQ-035 When full, hold in_valid=1 (0xAA) 3 cycles, out_ready=0 -> drop_cnt=3, contents unchanged; then pop 8 -> 0x11..0x18 in order, out_valid=0 after.
REQ-036 Continuous in_valid/out_ready with 20 flits 0x00..0x13 from empty -> count settles at 1, output sequence 0x00..0x13 in order, pointers wrap twice, no drops.
REQ-037 Full FIFO, in_valid=1 and out_ready=1 one cycle -> count 7, head popped, push refused, drop_cnt+1.
REQ-038 Load 5 flits, assert flush with in_valid and out_ready high -> next cycle count=0, out_valid=0, in_ready=1; next push appears as head.
REQ-039 Load 4 flits, pulse rst low between edges -> immediate count=0, out_valid=0, drop_cnt=0; after release, push 0x5A -> out_data=0x5A next cycle.
